booth_divider_seq: RTL and testbench

//  Sequential signed integer divider; the inverse of the N-bit Booth multiplier.
//  Non-restoring radix-2 datapath, one quotient bit per clock.

---
 rtl/arith_pkg.sv | 15 +
 rtl/booth_divider_seq_if.sv | 24 ++
 rtl/nr_div_step.sv | 18 +
 rtl/booth_divider_seq.sv | 165 ++++++++++++++++
 tb/tb_booth_divider_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM state encoding and constants.
package arith_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_PREP = 3'd1;
    localparam logic [STATE_W-1:0] ST_ITER = 3'd2;
    localparam logic [STATE_W-1:0] ST_FIX  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    // Quotient reported on divide-by-zero (-1 at any width); cast down to N bits at use.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/booth_divider_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface booth_divider_seq_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/nr_div_step.sv
// One non-restoring radix-2 iteration on unsigned magnitudes: shift {P,Q}, add/subtract D.
module nr_div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   i_p,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_d,
    output logic [N:0]   o_p_c,
    output logic [N-1:0] o_q_c
);
    logic [N:0] w_p_sh;

    assign w_p_sh = {i_p[N-1:0], i_q[N-1]};
    // The sign of P before the shift selects subtract (P >= 0) or add-back (P < 0).
    assign o_p_c  = i_p[N] ? (w_p_sh + {1'b0, i_d}) : (w_p_sh - {1'b0, i_d});
    assign o_q_c  = {i_q[N-2:0], ~o_p_c[N]};

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: magnitude non-restoring iteration, one quotient bit per clock,
// with sign fix-up and divide-by-zero / overflow overrides applied before the DONE cycle.
module booth_divider_seq
    import arith_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_divider_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(N);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               w_latch;
    logic               w_prep;
    logic               w_iter;
    logic               w_fix;

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N:0]    r_p;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_dbz;
    logic          r_ovf;

    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz_out;
    logic          r_ovf_out;

    logic [N:0]    w_p_step;
    logic [N-1:0]  w_q_step;
    logic [N-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic [N-1:0]  w_r_mag;
    logic [N-1:0]  w_q_res;
    logic [N-1:0]  w_r_res;

    nr_div_step #(.N(N)) u_step (
        .i_p   (r_p),
        .i_q   (r_q),
        .i_d   (r_d),
        .o_p_c (w_p_step),
        .o_q_c (w_q_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next_state = ST_PREP;
            ST_PREP: w_next_state = ST_ITER;
            ST_ITER: if (r_cnt == CW'(N - 1)) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state datapath enables
    always_comb begin
        w_latch = 1'b0;
        w_prep  = 1'b0;
        w_iter  = 1'b0;
        w_fix   = 1'b0;
        case (r_state)
            ST_IDLE: w_latch = bus.start;
            ST_PREP: w_prep  = 1'b1;
            ST_ITER: w_iter  = 1'b1;
            ST_FIX:  w_fix   = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes; |-2^(N-1)| wraps to 2^(N-1), which is exact as an unsigned N-bit value.
    assign w_a_mag = r_a[N-1] ? -r_a : r_a;
    assign w_b_mag = r_b[N-1] ? -r_b : r_b;

    // Final remainder correction; the true remainder is below D, so N bits suffice.
    assign w_r_mag = r_p[N] ? (r_p[N-1:0] + r_d) : r_p[N-1:0];

    always_comb begin
        w_q_res = r_neg_q ? -r_q : r_q;
        w_r_res = r_neg_r ? -w_r_mag : w_r_mag;
        if (r_dbz) begin
            w_q_res = N'(DIV0_QUOT);
            w_r_res = r_a;
        end else if (r_ovf) begin
            w_q_res = {1'b1, {(N-1){1'b0}}};
            w_r_res = '0;
        end
    end

    // Operand capture, iteration registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz_out <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_DONE);
            if (w_latch) begin
                r_a <= bus.dividend;
                r_b <= bus.divisor;
            end
            if (w_prep) begin
                r_p     <= '0;
                r_q     <= w_a_mag;
                r_d     <= w_b_mag;
                r_cnt   <= '0;
                r_neg_q <= r_a[N-1] ^ r_b[N-1];
                r_neg_r <= r_a[N-1];
                r_dbz   <= (r_b == '0);
                r_ovf   <= (r_a == {1'b1, {(N-1){1'b0}}}) && (r_b == '1);
            end
            if (w_iter) begin
                r_p   <= w_p_step;
                r_q   <= w_q_step;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fix) begin
                r_quot    <= w_q_res;
                r_rem     <= w_r_res;
                r_dbz_out <= r_dbz;
                r_ovf_out <= r_ovf;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz_out;
    assign bus.overflow    = r_ovf_out;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench: directed table, handshake corner cases, random N=8 and exhaustive N=4.
module tb_booth_divider_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_divider_seq_if #(.N(8)) bus8 ();
    booth_divider_seq_if #(.N(4)) bus4 ();

    booth_divider_seq #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    booth_divider_seq #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a; int b; int q; int r; int dbz; int ovf;
    } vec_t;

    int g_q, g_r, g_dbz, g_ovf, g_lat, g_busy;
    int g_done_after, g_busy_after, g_q_after, g_r_after;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: truncating signed division with the two special cases layered on top.
    function automatic void model(input int n, input int a, input int b,
                                  output int q, output int r, output int dbz, output int ovf);
        int lim;
        lim = 1 << (n - 1);
        dbz = 0;
        ovf = 0;
        if (b == 0) begin
            q = -1; r = a; dbz = 1;
        end else if (a == -lim && b == -1) begin
            q = -lim; r = 0; ovf = 1;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Issue one op on the N=8 unit; optionally pulse start mid-op or during the done cycle.
    task automatic op8(input int a, input int b, input int poke_at, input bit done_poke);
        int lat;
        int bcnt;
        for (int i = 0; i < 20 && bus8.busy; i++) @(negedge clk);
        bus8.start = 1'b1;
        bus8.dividend = 8'(a);
        bus8.divisor = 8'(b);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.dividend = 8'($urandom);
        bus8.divisor = 8'($urandom);
        lat = 0;
        bcnt = 0;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) bcnt++;
            bus8.start = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        if (bus8.busy) bcnt++;
        g_lat  = lat;
        g_busy = bcnt;
        g_q    = int'($signed(bus8.quotient));
        g_r    = int'($signed(bus8.remainder));
        g_dbz  = int'(bus8.div_by_zero);
        g_ovf  = int'(bus8.overflow);
        bus8.start = done_poke;
        @(negedge clk);
        bus8.start = 1'b0;
        g_done_after = int'(bus8.done);
        g_busy_after = int'(bus8.busy);
        g_q_after    = int'($signed(bus8.quotient));
        g_r_after    = int'($signed(bus8.remainder));
    endtask

    task automatic check_op8(input string tag, input int eq, input int er,
                             input int edbz, input int eovf);
        check({tag, " quotient"},    g_q, eq);
        check({tag, " remainder"},   g_r, er);
        check({tag, " div_by_zero"}, g_dbz, edbz);
        check({tag, " overflow"},    g_ovf, eovf);
        check({tag, " latency"},     g_lat, 10);
        check({tag, " busy cycles"}, g_busy, 11);
        check({tag, " done width"},  g_done_after, 0);
        check({tag, " busy fall"},   g_busy_after, 0);
        check({tag, " q held"},      g_q_after, eq);
        check({tag, " r held"},      g_r_after, er);
    endtask

    task automatic run_model8(input int a, input int b);
        int q, r, dbz, ovf;
        model(8, a, b, q, r, dbz, ovf);
        op8(a, b, -1, 1'b0);
        check_op8($sformatf("rnd %0d/%0d", a, b), q, r, dbz, ovf);
    endtask

    task automatic run4(input int a, input int b);
        int q, r, dbz, ovf, lat;
        string tag;
        model(4, a, b, q, r, dbz, ovf);
        tag = $sformatf("n4 %0d/%0d", a, b);
        for (int i = 0; i < 20 && bus4.busy; i++) @(negedge clk);
        bus4.start = 1'b1;
        bus4.dividend = 4'(a);
        bus4.divisor = 4'(b);
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.dividend = 4'($urandom);
        bus4.divisor = 4'($urandom);
        lat = 0;
        while (!bus4.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"},     lat, 6);
        check({tag, " quotient"},    int'($signed(bus4.quotient)), q);
        check({tag, " remainder"},   int'($signed(bus4.remainder)), r);
        check({tag, " div_by_zero"}, int'(bus4.div_by_zero), dbz);
        check({tag, " overflow"},    int'(bus4.overflow), ovf);
    endtask

    vec_t vecs[8];

    initial begin
        int seen;
        bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;

        vecs[0] = '{a:  100, b:  7, q:   14, r:   2, dbz: 0, ovf: 0};
        vecs[1] = '{a: -100, b:  7, q:  -14, r:  -2, dbz: 0, ovf: 0};
        vecs[2] = '{a:  100, b: -7, q:  -14, r:   2, dbz: 0, ovf: 0};
        vecs[3] = '{a: -100, b: -7, q:   14, r:  -2, dbz: 0, ovf: 0};
        vecs[4] = '{a: -128, b: -1, q: -128, r:   0, dbz: 0, ovf: 1};
        vecs[5] = '{a: -128, b:  1, q: -128, r:   0, dbz: 0, ovf: 0};
        vecs[6] = '{a:   37, b:  0, q:   -1, r:  37, dbz: 1, ovf: 0};
        vecs[7] = '{a:    6, b:  3, q:    2, r:   0, dbz: 0, ovf: 0};

        repeat (3) @(negedge clk);
        check("reset busy",      int'(bus8.busy), 0);
        check("reset done",      int'(bus8.done), 0);
        check("reset quotient",  int'(bus8.quotient), 0);
        check("reset remainder", int'(bus8.remainder), 0);
        check("reset n4 busy",   int'(bus4.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, -1, 1'b0);
            check_op8($sformatf("vec %0d/%0d", vecs[i].a, vecs[i].b),
                      vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
        end

        // A start pulsed mid-operation must be dropped without disturbing the running op.
        op8(100, 7, 3, 1'b0);
        check_op8("poke mid-op", 14, 2, 0, 0);

        // A start during the done cycle must also be dropped.
        op8(-100, -7, -1, 1'b1);
        check_op8("poke at done", 14, -2, 0, 0);

        // Reset asserted mid-iteration: outputs clear at once and no done ever follows.
        op8(55, 9, -1, 1'b0);
        bus8.start = 1'b1; bus8.dividend = 8'(-77); bus8.divisor = 8'(5);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",      int'(bus8.busy), 0);
        check("abort done",      int'(bus8.done), 0);
        check("abort quotient",  int'(bus8.quotient), 0);
        check("abort remainder", int'(bus8.remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) seen = 1;
        end
        check("abort no done", seen, 0);
        op8(-77, 5, -1, 1'b0);
        check_op8("after abort", -15, -2, 0, 0);

        // Random operands back-to-back against the reference model.
        for (int i = 0; i < 150; i++) begin
            int a, b;
            a = int'($urandom_range(255)) - 128;
            b = (i % 10 == 0) ? 0 : int'($urandom_range(255)) - 128;
            run_model8(a, b);
        end

        for (int a = -8; a < 8; a++)
            for (int b = -8; b < 8; b++)
                run4(a, b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
